// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM with a memory wait handshake and a retired-instruction counter.
// Control outputs are registered alongside the state, then qualified by reset, mem_ready and opcode.
module mc_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] instr_retired
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Moore control word for a state; FETCH's ir_write/pc_write are later gated by mem_ready.
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
         end
         DECODE:         c.alu_src_b = 2'b11;
         MEMADR, ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD:  begin c.mem_read  = 1'b1; c.iord = 1'b1; end
         MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
         MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
         ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         ADDIWB: c.reg_write = 1'b1;
         BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state, next_state;
   ctrl_t  ctrl_q;
   logic   legal_op;
   logic   retire;
   logic   active;

   always_comb begin
      legal_op = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                 (opcode == OP_BEQ)   || (opcode == OP_J)  || (opcode == OP_ADDI);
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH:  if (mem_ready) next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_RTYPE:      next_state = EXEC;
               OP_LW, OP_SW:  next_state = MEMADR;
               OP_BEQ:        next_state = BRANCH;
               OP_J:          next_state = JUMP;
               OP_ADDI:       next_state = ADDIEX;
               default:       next_state = FETCH;
            endcase
         end
         MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:  if (mem_ready) next_state = MEMWB;
         MEMWR:  if (mem_ready) next_state = FETCH;
         EXEC:   next_state = ALUWB;
         ADDIEX: next_state = ADDIWB;
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: next_state = FETCH;
         default: next_state = FETCH;
      endcase
   end

   always_comb begin
      retire = (state == MEMWB) || (state == ALUWB) || (state == ADDIWB) ||
               (state == BRANCH) || (state == JUMP) || ((state == MEMWR) && mem_ready);
   end

   // NOTE: the control word is loaded from next_state so it is valid in the same cycle the state is.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= FETCH;
         ctrl_q        <= decode_ctrl(FETCH);
         instr_retired <= '0;
      end else begin
         state  <= next_state;
         ctrl_q <= decode_ctrl(next_state);
         if (retire) instr_retired <= instr_retired + CNT_W'(1);
      end
   end

   always_comb begin
      active        = ~reset;
      pc_write      = active & ctrl_q.pc_write & ((state != FETCH) | mem_ready);
      ir_write      = active & ctrl_q.ir_write & mem_ready;
      pc_write_cond = active & ctrl_q.pc_write_cond;
      iord          = active & ctrl_q.iord;
      mem_read      = active & ctrl_q.mem_read;
      mem_write     = active & ctrl_q.mem_write;
      mem_to_reg    = active & ctrl_q.mem_to_reg;
      reg_dst       = active & ctrl_q.reg_dst;
      reg_write     = active & ctrl_q.reg_write;
      alu_src_a     = active & ctrl_q.alu_src_a;
      alu_src_b     = {2{active}} & ctrl_q.alu_src_b;
      alu_op        = {2{active}} & ctrl_q.alu_op;
      pc_source     = {2{active}} & ctrl_q.pc_source;
      illegal_op    = active & (state == DECODE) & ~legal_op;
      state_dbg     = state;
   end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle state and control-word checks against a table of
// expected outputs, plus retire-counter checks on a 16-bit and a 2-bit instance.
module tb_mc_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state_dbg;
   logic [15:0] instr_retired;

   logic        s_pc_write, s_pc_write_cond, s_iord, s_mem_read, s_mem_write, s_ir_write;
   logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a, s_illegal_op;
   logic [1:0]  s_alu_src_b, s_alu_op, s_pc_source;
   logic [3:0]  s_state_dbg;
   logic [1:0]  s_instr_retired;

   logic [16:0] ctrl_vec;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg),
      .instr_retired(instr_retired)
   );

   mc_control #(.CNT_W(2)) dut_small (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .iord(s_iord),
      .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
      .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst), .reg_write(s_reg_write),
      .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
      .pc_source(s_pc_source), .illegal_op(s_illegal_op), .state_dbg(s_state_dbg),
      .instr_retired(s_instr_retired)
   );

   assign ctrl_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word, same bit order as ctrl_vec, taken from the per-state output table.
   function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy,
                                            input logic [5:0] opc, input logic rst);
      logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
      logic [1:0] sb, op, ps;
      {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
      sb = 2'b00; op = 2'b00; ps = 2'b00;
      case (st)
         4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
         4'd1:  begin
            sb  = 2'b11;
            ill = !(opc inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
         end
         4'd2, 4'd9: begin sa = 1'b1; sb = 2'b10; end
         4'd3:  begin mr = 1'b1; io = 1'b1; end
         4'd4:  begin rw = 1'b1; m2r = 1'b1; end
         4'd5:  begin mw = 1'b1; io = 1'b1; end
         4'd6:  begin sa = 1'b1; op = 2'b10; end
         4'd7:  begin rw = 1'b1; rd = 1'b1; end
         4'd8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
         4'd10: rw = 1'b1;
         4'd11: begin pw = 1'b1; ps = 2'b10; end
         default: ;
      endcase
      if (rst) return '0;
      return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ill};
   endfunction

   // Apply inputs for one cycle, check state and controls mid-cycle, then cross the next edge.
   task automatic step(input logic [5:0] opc, input logic rdy, input logic [3:0] exp_st);
      opcode    = opc;
      mem_ready = rdy;
      #1;
      check("state_dbg", 32'(state_dbg), 32'(exp_st));
      check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(exp_st, rdy, opc, reset)));
      @(posedge clk);
      #1;
   endtask

   logic [1:0] small_exp [5];

   initial begin
      small_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      reset     = 1'b1;
      mem_ready = 1'b1;
      opcode    = OP_R;

      // Reset held two cycles: controls forced low, state FETCH, counter cleared.
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("reset_ctrl", 32'(ctrl_vec), 32'h0);
         check("reset_state", 32'(state_dbg), 32'h0);
         check("reset_cnt", 32'(instr_retired), 32'h0);
      end
      reset = 1'b0;

      // lw, no waits: 0,1,2,3,4 then back to FETCH.
      step(OP_LW, 1'b1, 4'd0);
      step(OP_LW, 1'b1, 4'd1);
      step(OP_LW, 1'b1, 4'd2);
      step(OP_LW, 1'b1, 4'd3);
      step(OP_LW, 1'b1, 4'd4);
      check("lw_cnt", 32'(instr_retired), 32'd1);

      // sw with one FETCH wait and three MEMWR waits.
      step(OP_SW, 1'b0, 4'd0);
      step(OP_SW, 1'b1, 4'd0);
      step(OP_SW, 1'b1, 4'd1);
      step(OP_SW, 1'b1, 4'd2);
      for (int i = 0; i < 3; i++) step(OP_SW, 1'b0, 4'd5);
      check("sw_wait_cnt", 32'(instr_retired), 32'd1);
      step(OP_SW, 1'b1, 4'd5);
      check("sw_cnt", 32'(instr_retired), 32'd2);
      check("sw_cnt_small", 32'(s_instr_retired), 32'd2);

      // R-type, beq, j, addi back to back: 14 cycles.
      step(OP_R, 1'b1, 4'd0);    step(OP_R, 1'b1, 4'd1);
      step(OP_R, 1'b1, 4'd6);    step(OP_R, 1'b1, 4'd7);
      step(OP_BEQ, 1'b1, 4'd0);  step(OP_BEQ, 1'b1, 4'd1);  step(OP_BEQ, 1'b1, 4'd8);
      step(OP_J, 1'b1, 4'd0);    step(OP_J, 1'b1, 4'd1);    step(OP_J, 1'b1, 4'd11);
      step(OP_ADDI, 1'b1, 4'd0); step(OP_ADDI, 1'b1, 4'd1);
      step(OP_ADDI, 1'b1, 4'd9); step(OP_ADDI, 1'b1, 4'd10);
      check("mix_cnt", 32'(instr_retired), 32'd6);
      check("mix_cnt_small", 32'(s_instr_retired), 32'd2);

      // Illegal opcode: illegal_op pulses in DECODE, back to FETCH, no retire.
      step(OP_BAD, 1'b1, 4'd0);
      step(OP_BAD, 1'b1, 4'd1);
      opcode = OP_R;
      #1;
      check("illegal_next", 32'(state_dbg), 32'd0);
      check("illegal_pulse_end", 32'(illegal_op), 32'd0);
      check("illegal_cnt", 32'(instr_retired), 32'd6);

      // Fresh reset, then five jumps: 2-bit counter wraps.
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst2_cnt", 32'(instr_retired), 32'd0);
      for (int k = 0; k < 5; k++) begin
         step(OP_J, 1'b1, 4'd0);
         step(OP_J, 1'b1, 4'd1);
         step(OP_J, 1'b1, 4'd11);
         check("j_cnt", 32'(instr_retired), 32'(k + 1));
         check("j_cnt_small", 32'(s_instr_retired), 32'(small_exp[k]));
      end

      // lw abandoned by reset in MEMRD.
      step(OP_LW, 1'b1, 4'd0);
      step(OP_LW, 1'b1, 4'd1);
      step(OP_LW, 1'b1, 4'd2);
      reset = 1'b1;
      #1;
      check("memrd_rst_state", 32'(state_dbg), 32'd3);
      check("memrd_rst_ctrl", 32'(ctrl_vec), 32'h0);
      @(posedge clk);
      #1;
      check("memrd_rst_next", 32'(state_dbg), 32'd0);
      check("memrd_rst_regw", 32'(reg_write), 32'd0);
      check("memrd_rst_cnt", 32'(instr_retired), 32'd0);
      reset = 1'b0;
      step(OP_J, 1'b1, 4'd0);
      step(OP_J, 1'b1, 4'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle main control FSM for the MIPS processor.
- Sequences the shared datapath (PC, instruction register, register file, single ALU, unified memory) through fetch, decode, execute, memory and writeback steps.
- Outputs are Moore-style, decoded from the state register.
- Adds a memory wait handshake and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load instruction register.
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=sequential increment constant, 10=sext imm16, 11=sext imm16 branch-scaled.
- alu_op  out  2  00=add, 01=sub, 10=use funct.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target {pc[hi], addr26}.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- state_dbg  out  4  current state encoding.
- instr_retired  out  CNT_W  count of completed instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Encodings 12-15 unused; if reached, next state = FETCH.
- Reset:
  - Next state = FETCH; instr_retired = 0.
  - While reset is high, every control output is forced to 0.
  - state_dbg still shows the registered state.
- Reset mid-instruction: the instruction is abandoned with no further writes. The counter is not incremented in that cycle.
- Outputs per state (unlisted outputs = 0):
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write = mem_ready. Stays in FETCH while mem_ready=0; PC and IR are unchanged while waiting.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target into ALUOut).
  - MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, iord=1. Waits for mem_ready.
  - MEMWR: mem_write=1, iord=1. Waits for mem_ready.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write=1, mem_to_reg=0, reg_dst=1.
  - ADDIWB: reg_write=1, mem_to_reg=0, reg_dst=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
- Transitions:
  - FETCH -> DECODE when mem_ready=1.
  - DECODE branches on opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) -> MEMADR
    - 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - any other opcode -> FETCH, with illegal_op=1 during that DECODE cycle. The PC has already advanced, so the instruction is skipped.
  - MEMADR -> MEMRD (lw) or MEMWR (sw). The opcode is re-sampled from the IR, which is stable.
  - MEMRD -> MEMWB on mem_ready.
  - MEMWR -> FETCH on mem_ready.
  - EXEC -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Latency with mem_ready always 1: lw 5 cycles; R-type, addi and sw 4 cycles; beq and j 3 cycles. Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Retire: instr_retired increments by 1 on the clock edge leaving the final state of a legal instruction (MEMWB, MEMWR with mem_ready, ALUWB, ADDIWB, BRANCH, JUMP).
  - Increments whether or not a beq is taken.
  - Wraps from all-ones to 0 modulo 2^CNT_W.
  - Illegal opcodes are not counted.
- mem_read and mem_write are never asserted in the same cycle. ir_write is asserted only in FETCH.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> all controls 0 during reset; state_dbg=0; instr_retired=0; first FETCH cycle shows mem_read=1, ir_write=1, pc_write=1.
- lw (opcode 100011) with mem_ready=1 -> state_dbg sequence 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 only in state 4; instr_retired=1 after 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held 4 cycles with iord=1; no reg_write at any point; retire only on the edge where mem_ready=1.
- Sequence R-type, beq, j, addi -> state_dbg 0,1,6,7 | 0,1,8 | 0,1,11 | 0,1,9,10; pc_source=01 in state 8 and 10 in state 11; instr_retired=4 after 14 cycles.
- Opcode 111111 -> illegal_op pulses for 1 cycle in DECODE; next state 0; instr_retired unchanged.
- CNT_W=2, five back-to-back j instructions -> instr_retired reads 1,2,3,0,1; reset asserted in MEMRD -> next state 0, with no reg_write and no increment.
